// File: rtl/platform_scheduler_if.sv
// Bundle between platform_scheduler and its neighbours: ball/scroll inputs from jumplogic,
// the color_mapper read port, and the per-frame status outputs.
interface platform_scheduler_if #(
    parameter int NUM_PLAT = 8
);
    localparam int IDXW = $clog2(NUM_PLAT);

    // No back-pressure anywhere: a frame is started by frame_clk alone, and frame_done/land are
    // one-cycle strobes that qualify land_y and respawn_cnt; rd_x/rd_y follow rd_idx combinationally.
    logic [9:0]      BallX;
    logic [9:0]      BallY;
    logic [9:0]      BallS;
    logic            ball_falling;
    logic [3:0]      scroll;
    logic [IDXW-1:0] rd_idx;
    logic [9:0]      rd_x;
    logic [9:0]      rd_y;
    logic            busy;
    logic            land;
    logic [9:0]      land_y;
    logic            frame_done;
    logic            overrun;
    logic [15:0]     respawn_cnt;
    logic [1:0]      dbg_state;

    modport master (
        output BallX, BallY, BallS, ball_falling, scroll, rd_idx,
        input  rd_x, rd_y, busy, land, land_y, frame_done, overrun, respawn_cnt, dbg_state
    );

    modport slave (
        input  BallX, BallY, BallS, ball_falling, scroll, rd_idx,
        output rd_x, rd_y, busy, land, land_y, frame_done, overrun, respawn_cnt, dbg_state
    );
endinterface

// File: rtl/platform_scheduler.sv
// Per-frame platform table scroller/recycler and ball landing scanner.
// Optional macro PLATFORM_SCHED_LFSR_EN: recycled slots take a pseudo-random column from a 16-bit LFSR.
module platform_scheduler #(
    parameter int          NUM_PLAT = 8,
    parameter int          PLAT_W   = 40,
    parameter int          PLAT_H   = 8,
    parameter int          SCREEN_W = 640,
    parameter int          SCREEN_H = 480,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_clk,
    platform_scheduler_if.slave  bus
);
    localparam int IDXW    = $clog2(NUM_PLAT);
    localparam int X_SPAN  = SCREEN_W - PLAT_W;
    localparam int ROW_GAP = SCREEN_H / NUM_PLAT;

    if (SEED == 16'h0 || NUM_PLAT < 2 || NUM_PLAT > 16 || (NUM_PLAT & (NUM_PLAT - 1)) != 0) begin : g_bad_param
        $error("platform_scheduler: SEED must be nonzero and NUM_PLAT a power of 2 in 2..16");
    end

    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_COLLIDE, S_DONE} state_e;

    state_e          state_q;
    logic            fs1_q, fs2_q, fs3_q, evt_q;
    logic [IDXW-1:0] idx_q;
    logic [9:0]      x_q [NUM_PLAT];
    logic [9:0]      y_q [NUM_PLAT];
    logic [3:0]      scroll_q;
    logic [9:0]      ballx_q, bally_q, balls_q;
    logic            falling_q;
    logic            hit_found_q;
    logic [9:0]      hit_y_q;
    logic            busy_q, land_q, frame_done_q, overrun_q;
    logic [9:0]      land_y_q;
    logic [15:0]     respawn_q;

    logic [9:0]  cur_x_d, cur_y_d, y_next_d;
    logic [10:0] ny_d, ball_bot_d, ball_right_d, plat_bot_d, plat_reach_d;
    logic        wrap_d, hit_d, last_d;

    always_comb begin
        cur_x_d      = x_q[idx_q];
        cur_y_d      = y_q[idx_q];
        ny_d         = {1'b0, cur_y_d} + {7'b0, scroll_q};
        wrap_d       = ny_d >= 11'(SCREEN_H);
        y_next_d     = wrap_d ? 10'(ny_d - 11'(SCREEN_H)) : ny_d[9:0];
        // All collision sums are 11 bits so nothing near the screen edges can wrap.
        ball_bot_d   = {1'b0, bally_q} + {1'b0, balls_q};
        ball_right_d = {1'b0, ballx_q} + {1'b0, balls_q};
        plat_bot_d   = {1'b0, cur_y_d} + 11'(PLAT_H);
        plat_reach_d = {1'b0, cur_x_d} + 11'(PLAT_W) + {1'b0, balls_q};
        hit_d        = falling_q
                    && (ball_bot_d >= {1'b0, cur_y_d}) && (ball_bot_d < plat_bot_d)
                    && (ball_right_d >= {1'b0, cur_x_d}) && ({1'b0, ballx_q} <= plat_reach_d);
        last_d       = idx_q == IDXW'(NUM_PLAT - 1);
    end

`ifdef PLATFORM_SCHED_LFSR_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_next_d;
    logic [9:0]  new_col_d;

    // Fibonacci x^16+x^14+x^13+x^11+1; the column is taken from the stepped value.
    always_comb begin
        lfsr_next_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        new_col_d   = {1'b0, lfsr_next_d[8:0]} + (lfsr_next_d[9] ? 10'd80 : 10'd0);
    end
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            fs1_q        <= 1'b0;
            fs2_q        <= 1'b0;
            fs3_q        <= 1'b0;
            evt_q        <= 1'b0;
            idx_q        <= '0;
            scroll_q     <= '0;
            ballx_q      <= '0;
            bally_q      <= '0;
            balls_q      <= '0;
            falling_q    <= 1'b0;
            hit_found_q  <= 1'b0;
            hit_y_q      <= '0;
            busy_q       <= 1'b0;
            land_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            land_y_q     <= '0;
            respawn_q    <= '0;
            for (int i = 0; i < NUM_PLAT; i++) begin
                x_q[i] <= 10'((16 + 64 * i) % X_SPAN);
                y_q[i] <= 10'(i * ROW_GAP);
            end
`ifdef PLATFORM_SCHED_LFSR_EN
            lfsr_q       <= SEED;
`endif
        end else begin
            fs1_q        <= frame_clk;
            fs2_q        <= fs1_q;
            fs3_q        <= fs2_q;
            evt_q        <= fs2_q & ~fs3_q;
            land_q       <= 1'b0;
            frame_done_q <= 1'b0;
            if (evt_q && state_q != S_IDLE) overrun_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (evt_q) begin
                        scroll_q    <= bus.scroll;
                        ballx_q     <= bus.BallX;
                        bally_q     <= bus.BallY;
                        balls_q     <= bus.BallS;
                        falling_q   <= bus.ball_falling;
                        idx_q       <= '0;
                        hit_found_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    y_q[idx_q] <= y_next_d;
                    if (wrap_d) begin
                        respawn_q <= respawn_q + 16'd1;
`ifdef PLATFORM_SCHED_LFSR_EN
                        x_q[idx_q] <= new_col_d;
                        lfsr_q     <= lfsr_next_d;
`endif
                    end
                    idx_q <= last_d ? '0 : idx_q + 1'b1;
                    if (last_d) state_q <= S_COLLIDE;
                end
                S_COLLIDE: begin
                    if (hit_d && !hit_found_q) begin
                        hit_found_q <= 1'b1;
                        hit_y_q     <= cur_y_d;
                    end
                    if (last_d) begin
                        frame_done_q <= 1'b1;
                        land_q       <= hit_found_q | hit_d;
                        if (hit_found_q)  land_y_q <= hit_y_q;
                        else if (hit_d)   land_y_q <= cur_y_d;
                        state_q      <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_x        = x_q[bus.rd_idx];
    assign bus.rd_y        = y_q[bus.rd_idx];
    assign bus.busy        = busy_q;
    assign bus.land        = land_q;
    assign bus.land_y      = land_y_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.overrun     = overrun_q;
    assign bus.respawn_cnt = respawn_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_platform_scheduler.sv
// Randomized scoreboard bench for platform_scheduler with a frame-level reference model.
module tb_platform_scheduler;
    localparam int W = 59;  // {due_cycle[31:0], land, land_y[9:0], respawn[15:0]}

    logic clk;
    logic rst;
    logic frame_clk;
    int   cyc;
    int   n_vec;
    int   n_err;

    logic [W-1:0] exp_q[$];

    // reference model state
    int mx[8];
    int my[8];
    int m_lfsr;
    int m_resp;
    int m_land_y;

    platform_scheduler_if #(.NUM_PLAT(8)) bus ();

    platform_scheduler dut (
        .Clk       (clk),
        .Reset     (rst),
        .frame_clk (frame_clk),
        .bus       (bus)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #10 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            mx[i] = (16 + 64 * i) % 600;
            my[i] = i * 60;
        end
        m_lfsr   = 16'hACE1;
        m_resp   = 0;
        m_land_y = 0;
    endfunction

    // one whole frame: scroll/recycle every slot, then find the first slot the ball lands on
    function automatic void model_frame(input int sc, input int bx, input int by, input int bs,
                                        input int fall, output int landed);
        int fb;
        for (int i = 0; i < 8; i++) begin
            if (my[i] + sc >= 480) begin
                my[i]  = my[i] + sc - 480;
                m_resp = (m_resp + 1) % 65536;
`ifdef PLATFORM_SCHED_LFSR_EN
                fb     = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
                m_lfsr = ((m_lfsr << 1) | fb) & 16'hFFFF;
                mx[i]  = (m_lfsr % 512) + (((m_lfsr / 512) % 2 == 1) ? 80 : 0);
`else
                fb     = 0;
`endif
            end else begin
                my[i] = my[i] + sc;
            end
        end
        landed = 0;
        for (int i = 0; i < 8; i++) begin
            if (landed == 0 && fall != 0 && by + bs >= my[i] && by + bs < my[i] + 8
                && bx + bs >= mx[i] && bx <= mx[i] + 40 + bs) begin
                landed   = 1;
                m_land_y = my[i];
            end
        end
    endfunction

    // monitor: pop and compare on every frame_done
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.frame_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency_cycle", cyc, int'(e[58:27]));
                    chk("land", int'(bus.land), int'(e[26]));
                    chk("land_y", int'(bus.land_y), int'(e[25:16]));
                    chk("respawn_cnt", int'(bus.respawn_cnt), int'(e[15:0]));
                end
            end else if (bus.land) begin
                chk("land_without_frame_done", 1, 0);
            end
        end
    end

    // driver tasks
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        model_reset();
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.rd_idx = 3'(i);
            #1;
            chk({tag, "_x"}, int'(bus.rd_x), mx[i]);
            chk({tag, "_y"}, int'(bus.rd_y), my[i]);
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 80 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            chk("frame_timeout", 1, 0);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
        chk("busy_after_frame", int'(bus.busy), 0);
    endtask

    task automatic run_frame(input int sc, input int bx, input int by, input int bs,
                             input int fall, input bit second_edge);
        int landed;
        @(negedge clk);
        bus.scroll       = 4'(sc);
        bus.BallX        = 10'(bx);
        bus.BallY        = 10'(by);
        bus.BallS        = 10'(bs);
        bus.ball_falling = 1'(fall);
        model_frame(sc, bx, by, bs, fall, landed);
        exp_q.push_back({32'(cyc + 20), 1'(landed), 10'(m_land_y), 16'(m_resp)});
        frame_clk = 1'b1;
        repeat (3) @(negedge clk);
        frame_clk = 1'b0;
        if (second_edge) begin
            repeat (7) @(negedge clk);
            chk("busy_mid_frame", int'(bus.busy), 1);
            frame_clk = 1'b1;
            repeat (3) @(negedge clk);
            frame_clk = 1'b0;
        end
        wait_drain();
    endtask

    task automatic random_frame();
        int j, bs, bx, by;
        j  = $urandom_range(0, 7);
        bs = $urandom_range(1, 15);
        bx = mx[j] + $urandom_range(0, 48) - 4;
        by = my[j] - bs + $urandom_range(0, 24) - 4;
        if ($urandom_range(0, 4) == 0) begin
            bx = $urandom_range(0, 639);
            by = $urandom_range(0, 479);
        end
        if (bx < 0) bx = 0;
        if (by < 0) by = 0;
        run_frame($urandom_range(0, 15), bx, by, bs, $urandom_range(0, 3) != 0 ? 1 : 0, 1'b0);
    endtask

    initial begin
        n_vec            = 0;
        n_err            = 0;
        rst              = 1'b1;
        frame_clk        = 1'b0;
        bus.BallX        = '0;
        bus.BallY        = '0;
        bus.BallS        = '0;
        bus.ball_falling = 1'b0;
        bus.scroll       = '0;
        bus.rd_idx       = '0;
        model_reset();
        do_reset();

        // reset state
        check_table("reset");
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_land", int'(bus.land), 0);
        chk("reset_frame_done", int'(bus.frame_done), 0);
        chk("reset_overrun", int'(bus.overrun), 0);
        chk("reset_land_y", int'(bus.land_y), 0);
        chk("reset_respawn", int'(bus.respawn_cnt), 0);

        // landing on slot 1 at (80,60) with scroll 0, then a near miss, then not falling
        run_frame(0, 100, 57, 4, 1, 1'b0);
        run_frame(0, 100, 55, 4, 1, 1'b0);
        run_frame(0, 100, 57, 4, 0, 1'b0);
        check_table("land");

        // plain scroll, then walk slot 7 to 478 and wrap it with scroll 4
        run_frame(5, 0, 0, 1, 0, 1'b0);
        check_table("scroll5");
        run_frame(15, 0, 0, 1, 0, 1'b0);
        run_frame(15, 0, 0, 1, 0, 1'b0);
        run_frame(15, 0, 0, 1, 0, 1'b0);
        run_frame(8, 0, 0, 1, 0, 1'b0);
        run_frame(4, 0, 0, 1, 0, 1'b0);
        check_table("wrap");

        // second frame edge while busy is dropped and latches overrun
        run_frame(3, 0, 0, 1, 0, 1'b1);
        chk("overrun_set", int'(bus.overrun), 1);
        run_frame(2, 0, 0, 1, 0, 1'b0);
        chk("overrun_sticky", int'(bus.overrun), 1);
        check_table("overrun");

        for (int f = 0; f < 40; f++) random_frame();
        check_table("random");

        // reset in the middle of COLLIDE: no pulses, table back to reset values
        @(negedge clk);
        bus.scroll = 4'd7;
        frame_clk  = 1'b1;
        repeat (3) @(negedge clk);
        frame_clk = 1'b0;
        repeat (11) @(negedge clk);
        chk("busy_before_abort", int'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        model_reset();
        repeat (30) @(negedge clk);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_overrun", int'(bus.overrun), 0);
        chk("abort_respawn", int'(bus.respawn_cnt), 0);
        chk("abort_land_y", int'(bus.land_y), 0);
        check_table("abort");

        for (int f = 0; f < 10; f++) random_frame();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
